// File: rtl/fence_t_sequencer_pkg.sv
// Shared types for the fence.t micro-reset sequencer.
// Contents: the sequencer state enum, the padding-source enum, privilege encodings
// and a helper that sizes a counter holding the values 0..n-1.
package fence_t_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFlush,
    StDrain,
    StPad,
    StRstUarch
  } fence_t_state_e;

  typedef enum logic [1:0] {
    PadTimerIrq = 2'd0,
    PadLeaveU   = 2'd1,
    PadNone0    = 2'd2,
    PadNone1    = 2'd3
  } pad_src_e;

  localparam logic [1:0] PrivU = 2'b00;
  localparam logic [1:0] PrivM = 2'b11;

  // Width needed to hold the values 0..n-1. Never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fence_t_sequencer_counter.sv
// Generic up/down counter with clear and load.
// Ports: clk, rst (sync, active-high), clear, load/d (load value), en (step by one),
// down (1 = decrement, 0 = increment), q (current count).
// Priority: rst > clear > load > en.
module fence_t_sequencer_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             en,
  input  logic             down,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = d;
    end else if (en) begin
      cnt_d = down ? cnt_q - 1'b1 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/fence_t_sequencer.sv
// fence.t micro-reset sequencer: flush -> drain -> pad -> micro-arch reset.
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   fence_t_i, pc_commit_i         fence.t commit pulse and its PC
//   boot_addr_i, rst_addr_o        reset value / fetch address after the sequence
//   flush_req_o, flush_ack_i       per-channel flush handshake (level req, pulse ack)
//   busy_i                         per-channel outstanding external traffic
//   pad_cycles_i, pad_src_i        padding length and padding trigger select
//   time_irq_i, priv_lvl_i         inputs to the padding trigger
//   halt_o, stall_o, uarch_rst_o   control into frontend / memory subsystem
//   pad_ceil_o, pad_ceil_valid_o   cycles consumed before PAD, with update pulse
//   done_o                         pulse on return to idle
module fence_t_sequencer
  import fence_t_sequencer_pkg::*;
#(
  parameter int unsigned NrChannels  = 2,
  parameter int unsigned DrainCycles = 16,
  parameter int unsigned RstCycles   = 16,
  parameter int unsigned PadWidth    = 32,
  parameter int unsigned VLEN        = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fence_t_i,
  input  logic [VLEN-1:0]       pc_commit_i,
  input  logic [VLEN-1:0]       boot_addr_i,
  output logic [VLEN-1:0]       rst_addr_o,
  output logic [NrChannels-1:0] flush_req_o,
  input  logic [NrChannels-1:0] flush_ack_i,
  input  logic [NrChannels-1:0] busy_i,
  input  logic [PadWidth-1:0]   pad_cycles_i,
  input  logic [1:0]            pad_src_i,
  input  logic                  time_irq_i,
  input  logic [1:0]            priv_lvl_i,
  output logic                  halt_o,
  output logic                  stall_o,
  output logic                  uarch_rst_o,
  output logic [PadWidth-1:0]   pad_ceil_o,
  output logic                  pad_ceil_valid_o,
  output logic                  done_o
);

  localparam int unsigned DrainW = cnt_width(DrainCycles);
  localparam int unsigned RstW   = cnt_width(RstCycles);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DrainCycles - 1);
  localparam logic [RstW-1:0]   RstLast   = RstW'(RstCycles - 1);

  fence_t_state_e        state_q, state_d;
  logic [NrChannels-1:0] pending_q, pending_d;
  logic [VLEN-1:0]       rst_addr_q, rst_addr_d;
  logic [PadWidth-1:0]   pad_ceil_q, pad_ceil_d;
  logic                  pad_ceil_valid_q, pad_ceil_valid_d;
  logic                  done_q, done_d;
  logic                  time_irq_q;
  logic [1:0]            priv_lvl_q;

  logic [DrainW-1:0]   drain_cnt;
  logic [PadWidth-1:0] pad_cnt;
  logic [RstW-1:0]     rst_cnt;
  logic                pad_trig, drain_exit, rst_last;

  always_comb begin
    pad_trig = 1'b0;
    unique case (pad_src_e'(pad_src_i))
      PadTimerIrq: pad_trig = time_irq_i & ~time_irq_q;
      PadLeaveU:   pad_trig = (priv_lvl_q == PrivU) && (priv_lvl_i != PrivU);
      default:     pad_trig = 1'b0;
    endcase
  end

  assign drain_exit = (drain_cnt == DrainLast) && (busy_i == '0);
  assign rst_last   = (state_q == StRstUarch) && (rst_cnt == RstLast);

  // Counts consecutive all-idle cycles, saturating once the drain window is met.
  fence_t_sequencer_counter #(
    .Width (DrainW)
  ) u_drain_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .clear (|busy_i),
    .load  (1'b0),
    .en    (drain_cnt != DrainLast),
    .down  (1'b0),
    .d     ('0),
    .q     (drain_cnt)
  );

  // Free-running padding budget: reloaded on each trigger, otherwise drains to zero.
  fence_t_sequencer_counter #(
    .Width (PadWidth)
  ) u_pad_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .clear (1'b0),
    .load  (pad_trig),
    .en    (pad_cnt != '0),
    .down  (1'b1),
    .d     (pad_cycles_i),
    .q     (pad_cnt)
  );

  // Cycles spent in RST_UARCH; held at zero outside it.
  fence_t_sequencer_counter #(
    .Width (RstW)
  ) u_rst_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .clear ((state_q != StRstUarch) || rst_last),
    .load  (1'b0),
    .en    (1'b1),
    .down  (1'b0),
    .d     ('0),
    .q     (rst_cnt)
  );

  always_comb begin
    state_d          = state_q;
    pending_d        = pending_q;
    rst_addr_d       = rst_addr_q;
    pad_ceil_d       = pad_ceil_q;
    pad_ceil_valid_d = 1'b0;
    done_d           = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fence_t_i) begin
          state_d    = StFlush;
          pending_d  = '1;
          rst_addr_d = pc_commit_i + VLEN'(4);
        end
      end
      StFlush: begin
        // Acks on already-cleared bits fall out of the AND naturally.
        pending_d = pending_q & ~flush_ack_i;
        if (pending_d == '0) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (drain_exit) begin
          state_d          = StPad;
          pad_ceil_valid_d = 1'b1;
          pad_ceil_d       = (pad_cnt == '0) ? '0 : pad_cycles_i - pad_cnt;
        end
      end
      StPad: begin
        if ((pad_cnt == '0) || pad_src_i[1]) begin
          state_d = StRstUarch;
        end
      end
      StRstUarch: begin
        if (rst_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= StIdle;
      pending_q        <= '0;
      rst_addr_q       <= boot_addr_i;
      pad_ceil_q       <= '0;
      pad_ceil_valid_q <= 1'b0;
      done_q           <= 1'b0;
      time_irq_q       <= 1'b0;
      priv_lvl_q       <= PrivM;
    end else begin
      state_q          <= state_d;
      pending_q        <= pending_d;
      rst_addr_q       <= rst_addr_d;
      pad_ceil_q       <= pad_ceil_d;
      pad_ceil_valid_q <= pad_ceil_valid_d;
      done_q           <= done_d;
      time_irq_q       <= time_irq_i;
      priv_lvl_q       <= priv_lvl_i;
    end
  end

  assign flush_req_o      = (state_q == StFlush) ? pending_q : '0;
  assign halt_o           = (state_q != StIdle);
  assign stall_o          = (state_q != StIdle);
  assign uarch_rst_o      = (state_q == StRstUarch);
  assign rst_addr_o       = rst_addr_q;
  assign pad_ceil_o       = pad_ceil_q;
  assign pad_ceil_valid_o = pad_ceil_valid_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_fence_t_sequencer.sv
// Self-checking bench for fence_t_sequencer: directed sequences plus random stimulus,
// every cycle compared against a behavioural model of the sequencing rules.
module tb_fence_t_sequencer;

  localparam int unsigned NrCh  = 3;
  localparam int unsigned Drain = 16;
  localparam int unsigned Rst   = 16;
  localparam int unsigned PW    = 32;
  localparam int unsigned VL    = 32;

  localparam int SIdle = 0, SFlush = 1, SDrain = 2, SPad = 3, SRst = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, fence_t, time_irq;
  logic [VL-1:0]   pc_commit, boot_addr, rst_addr;
  logic [NrCh-1:0] flush_req, flush_ack, busy;
  logic [PW-1:0]   pad_cycles, pad_ceil;
  logic [1:0]      pad_src, priv_lvl;
  logic            halt, stall, uarch_rst, pad_ceil_valid, done;

  int checks = 0;
  int failures = 0;

  fence_t_sequencer #(
    .NrChannels  (NrCh),
    .DrainCycles (Drain),
    .RstCycles   (Rst),
    .PadWidth    (PW),
    .VLEN        (VL)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .fence_t_i        (fence_t),
    .pc_commit_i      (pc_commit),
    .boot_addr_i      (boot_addr),
    .rst_addr_o       (rst_addr),
    .flush_req_o      (flush_req),
    .flush_ack_i      (flush_ack),
    .busy_i           (busy),
    .pad_cycles_i     (pad_cycles),
    .pad_src_i        (pad_src),
    .time_irq_i       (time_irq),
    .priv_lvl_i       (priv_lvl),
    .halt_o           (halt),
    .stall_o          (stall),
    .uarch_rst_o      (uarch_rst),
    .pad_ceil_o       (pad_ceil),
    .pad_ceil_valid_o (pad_ceil_valid),
    .done_o           (done)
  );

  // Behavioural model: phase, outstanding channel set, idle streak, pad budget,
  // cycles elapsed in the reset phase.
  int            m_st, m_idle, m_rel;
  logic [NrCh-1:0] m_pend;
  logic [PW-1:0] m_pad, m_ceil;
  logic          m_tq, m_valid, m_done;
  logic [1:0]    m_pq;
  logic [VL-1:0] m_raddr;

  task automatic model_reset();
    m_st = SIdle; m_pend = '0; m_idle = 0; m_pad = '0; m_rel = 0;
    m_tq = 1'b0; m_pq = 2'b11; m_raddr = boot_addr; m_ceil = '0;
    m_valid = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_step();
    logic          trig;
    int            n_idle;
    logic [PW-1:0] n_pad;
    if (rst) begin
      model_reset();
      return;
    end
    trig = (pad_src == 2'd0 && time_irq && !m_tq) ||
           (pad_src == 2'd1 && m_pq == 2'b00 && priv_lvl != 2'b00);
    n_idle = (busy != 0) ? 0 : ((m_idle < Drain - 1) ? m_idle + 1 : Drain - 1);
    n_pad  = trig ? pad_cycles : ((m_pad != 0) ? m_pad - 1 : '0);
    m_valid = 1'b0;
    m_done  = 1'b0;
    case (m_st)
      SIdle: if (fence_t) begin
        m_st = SFlush; m_pend = '1; m_raddr = pc_commit + 4;
      end
      SFlush: begin
        m_pend = m_pend & ~flush_ack;
        if (m_pend == 0) m_st = SDrain;
      end
      SDrain: if (m_idle == Drain - 1 && busy == 0) begin
        m_st = SPad; m_valid = 1'b1;
        m_ceil = (m_pad == 0) ? '0 : pad_cycles - m_pad;
      end
      SPad: if (m_pad == 0 || pad_src >= 2) begin
        m_st = SRst; m_rel = 0;
      end
      SRst: begin
        m_rel++;
        if (m_rel == Rst) begin
          m_st = SIdle; m_done = 1'b1; m_rel = 0;
        end
      end
      default: m_st = SIdle;
    endcase
    m_idle = n_idle; m_pad = n_pad; m_tq = time_irq; m_pq = priv_lvl;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("flush_req", 64'(flush_req), (m_st == SFlush) ? 64'(m_pend) : 64'd0);
    check("halt", 64'(halt), 64'(m_st != SIdle));
    check("stall", 64'(stall), 64'(m_st != SIdle));
    check("uarch_rst", 64'(uarch_rst), 64'(m_st == SRst));
    check("rst_addr", 64'(rst_addr), 64'(m_raddr));
    check("pad_ceil", 64'(pad_ceil), 64'(m_ceil));
    check("pad_ceil_valid", 64'(pad_ceil_valid), 64'(m_valid));
    check("done", 64'(done), 64'(m_done));
  endtask

  // Inputs stay stable across the edge; outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // which: 0 = done_o, 1 = uarch_rst_o, 2 = pad_ceil_valid_o
  task automatic wait_for(input int which, input int limit, output int n);
    n = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      n++;
      if ((which == 0 && done) || (which == 1 && uarch_rst) || (which == 2 && pad_ceil_valid))
        return;
    end
    check("wait_timeout", 64'd0, 64'd1);
  endtask

  // Fence plus all acks: fence sampled on the first edge, acks accepted on the second.
  task automatic fence_imm(input logic [VL-1:0] pc);
    pc_commit = pc; fence_t = 1'b1; flush_ack = '1;
    step();
    fence_t = 1'b0;
    step();
    flush_ack = '0;
  endtask

  typedef struct {
    logic [VL-1:0] pc;
    logic [VL-1:0] exp_addr;
    int            exp_lat;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int n, pad_len, last_busy, done_cnt;
    logic [PW-1:0] ceil_seen;

    vecs[0] = '{pc: 32'h8000_0ffc, exp_addr: 32'h8000_1000, exp_lat: 3 + Rst};
    vecs[1] = '{pc: 32'hffff_fffc, exp_addr: 32'h0000_0000, exp_lat: 3 + Rst};
    vecs[2] = '{pc: 32'h0000_0000, exp_addr: 32'h0000_0004, exp_lat: 3 + Rst};

    rst = 1'b1; fence_t = 1'b0; pc_commit = '0; boot_addr = 32'h0000_1000;
    flush_ack = '0; busy = '0; pad_cycles = '0; pad_src = 2'd2; time_irq = 1'b0;
    priv_lvl = 2'b11;
    model_reset();
    step();
    step();
    rst = 1'b0;
    check("reset_rst_addr", 64'(rst_addr), 64'h1000);
    check("reset_halt", 64'(halt), 64'd0);
    check("reset_flush_req", 64'(flush_req), 64'd0);
    idle(20);

    // Minimum latency and return address, no padding.
    foreach (vecs[v]) begin
      fence_imm(vecs[v].pc);
      wait_for(0, 100, n);
      check("min_latency", 64'(1 + n), 64'(vecs[v].exp_lat));
      check("ret_addr", 64'(rst_addr), 64'(vecs[v].exp_addr));
      step();
      check("done_single", 64'(done), 64'd0);
      // Spurious ack in idle is ignored.
      flush_ack = 3'b101;
      step();
      flush_ack = '0;
      check("idle_ack_req", 64'(flush_req), 64'd0);
      check("idle_ack_halt", 64'(halt), 64'd0);
      idle(20);
    end

    // Staggered acks: ch2 at edge 2, ch0 at edge 5, ch1 at edge 9.
    pc_commit = 32'h100;
    for (int k = 0; k < 12; k++) begin
      fence_t   = (k == 0);
      flush_ack = (k == 2) ? 3'b100 : (k == 5) ? 3'b001 : (k == 9) ? 3'b010 : 3'b000;
      step();
      check("stagger_req", 64'(flush_req),
            (k < 2) ? 64'b111 : (k < 5) ? 64'b011 : (k < 9) ? 64'b010 : 64'b000);
    end
    fence_t = 1'b0; flush_ack = '0;
    wait_for(0, 100, n);
    idle(20);

    // busy pulse inside DRAIN delays exit by a full idle window.
    pc_commit = 32'h200; fence_t = 1'b1; busy = 3'b010; flush_ack = '1;
    step();
    fence_t = 1'b0;
    for (int k = 1; k < 8; k++) step();
    flush_ack = '0; busy = '0;
    wait_for(2, 100, n);
    check("busy_drain_len", 64'(n), 64'(Drain));
    wait_for(0, 100, n);
    idle(20);

    // Timer-edge padding: ceiling 30, PAD lasts 70 cycles, fence during PAD ignored.
    pad_src = 2'd0; pad_cycles = 32'd100;
    idle(5);
    time_irq = 1'b1;
    idle(29);
    fence_imm(32'h300);
    wait_for(2, 10, n);
    ceil_seen = pad_ceil;
    check("pad_ceil_val", 64'(ceil_seen), 64'd30);
    pad_len = 0;
    for (int i = 0; i < 200 && !uarch_rst; i++) begin
      fence_t = (i == 10);
      step();
      pad_len++;
    end
    fence_t = 1'b0;
    check("pad_len", 64'(pad_len), 64'd70);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) done_cnt++;
    end
    check("pad_done_once", 64'(done_cnt), 64'd1);
    check("no_refence", 64'(halt), 64'd0);
    time_irq = 1'b0; pad_src = 2'd2;
    idle(20);

    // Reset in RST_UARCH aborts without done.
    boot_addr = 32'h0000_1234;
    fence_imm(32'h400);
    wait_for(1, 100, n);
    idle(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_halt", 64'(halt), 64'd0);
    check("abort_uarch", 64'(uarch_rst), 64'd0);
    check("abort_addr", 64'(rst_addr), 64'h1234);
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);

    // Random traffic against the model.
    last_busy = 0;
    for (int i = 0; i < 5000; i++) begin
      rst       = ($urandom_range(0, 799) == 0);
      fence_t   = ($urandom_range(0, 19) == 0);
      pc_commit = $urandom;
      for (int c = 0; c < NrCh; c++) begin
        flush_ack[c] = ($urandom_range(0, 3) == 0);
        busy[c]      = ($urandom_range(0, 24) == 0);
      end
      if ($urandom_range(0, 199) == 0) pad_src = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) pad_cycles = $urandom_range(0, 40);
      if ($urandom_range(0, 29) == 0) time_irq = ~time_irq;
      if ($urandom_range(0, 24) == 0) priv_lvl = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) boot_addr = $urandom;
      step();
      last_busy = i;
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fence_t_sequencer.md
# fence_t_sequencer

Parametrised fence.t micro-reset sequencer for the CVA6 core. It replaces the single-cache fence.t FSM in the flush controller and drives the flush/drain/pad/reset sequence that removes timing channels. It supports N independently acknowledged flush channels (I$, D$, TLBs, BP, …), configurable drain and reset lengths, and a selectable padding source. It sits beside the flush controller: it takes the fence.t pulse from commit and drives halt, stall and cache-init control into the frontend and memory subsystem.

## Interface
Parameters:
- NrChannels, 2: number of flush channels; each has its own req/ack/busy.
- DrainCycles, 16: consecutive all-idle cycles required before leaving DRAIN; range 1..256.
- RstCycles, 16: cycles `uarch_rst_o` is held; range 1..256.
- PadWidth, 32: width of the pad counter and the ceiling.
- VLEN, riscv::VLEN: address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. Synchronous, active-high.
- fence_t_i  in  1  single-cycle fence.t commit pulse.
- pc_commit_i  in  VLEN  PC of the committing fence.t.
- boot_addr_i  in  VLEN  reset value of `rst_addr_o`.
- rst_addr_o  out  VLEN  fetch address after micro-reset.
- flush_req_o  out  NrChannels  per-channel flush request; level signal.
- flush_ack_i  in  NrChannels  per-channel flush done; pulse.
- busy_i  in  NrChannels  channel has outstanding external transactions.
- pad_cycles_i  in  PadWidth  padding length, from CSR.
- pad_src_i  in  2  padding trigger: 0 = timer irq rising edge, 1 = leaving U-mode, 2/3 = no padding.
- time_irq_i  in  1  timer interrupt.
- priv_lvl_i  in  2  current privilege level.
- halt_o  out  1  halt commit.
- stall_o  out  1  caches refuse new requests.
- uarch_rst_o  out  1  cache/predictor re-init strobe.
- pad_ceil_o  out  PadWidth  cycles actually consumed before PAD.
- pad_ceil_valid_o  out  1  single-cycle pulse when `pad_ceil_o` updates.
- done_o  out  1  single-cycle pulse on return to IDLE.

## Operation
States: IDLE, FLUSH, DRAIN, PAD, RST_UARCH.

- **IDLE**
  - On `fence_t_i`: go to FLUSH.
  - Set `pending_q` to all ones.
  - Set `rst_addr_q <= pc_commit_i + 4` (VLEN-bit wrap).
- **FLUSH**
  - `flush_req_o = pending_q`.
  - `flush_ack_i[k]` clears `pending_q[k]`. An ack on a non-pending bit is ignored.
  - When `pending_q`, with this cycle's acks applied, is zero: go to DRAIN.
- **DRAIN**
  - Exit when the drain counter equals DrainCycles-1 and `busy_i` is all zero: go to PAD.
  - On that transition, register `pad_ceil_o` and pulse `pad_ceil_valid_o`:
    - `pad_ceil_o = 0` if the pad counter is 0;
    - otherwise `pad_ceil_o = pad_cycles_i - pad_cnt`, mod 2^PadWidth.
- **PAD**
  - Exit when the pad counter is 0, or when `pad_src_i >= 2`: go to RST_UARCH.
- **RST_UARCH**
  - `uarch_rst_o = 1`.
  - After RstCycles cycles in this state: go to IDLE, pulse `done_o`, clear the reset counter.

Counters:
- **Drain counter**
  - Runs in every state.
  - Cleared to 0 by any `busy_i` bit.
  - Otherwise increments, saturating at DrainCycles-1.
- **Pad counter**
  - Runs in every state.
  - Loads `pad_cycles_i` on the trigger event:
    - src 0: `time_irq_i & ~time_irq_q`;
    - src 1: `priv_lvl_q == U && priv_lvl_i != U`;
    - src 2/3: never.
  - Otherwise decrements while non-zero.
  - Load wins over decrement.

Outputs:
- `halt_o = stall_o = (state != IDLE)`.
- `fence_t_i` outside IDLE is ignored.

## Timing
- All outputs are registered or decoded from registered state; no comb path from an input to an output.
- `flush_req_o` rises the cycle after `fence_t_i`.
- An ack in the first req cycle is accepted.
- Minimum fence.t latency (`fence_t_i` to `done_o`) with immediate acks, idle channels, saturated drain counter and no padding: 1 (FLUSH) + 1 (DRAIN) + 1 (PAD) + RstCycles cycles.
- Reset values:
  - state IDLE; `pending_q` 0; all outputs 0;
  - `rst_addr_o = boot_addr_i`;
  - drain and pad counters 0;
  - `time_irq_q` 0; `priv_lvl_q` M.
- `rst_i` mid-sequence aborts immediately to the reset values. No `done_o`.

## Structure
- `fence_t_state_e` and `pad_src_e` live in ariane_pkg.
- Drain, pad and reset counters use common_cells `counter` instances.
- The FSM, `pending_q` and the edge detectors are local.

## Test plan
- NrChannels=3; acks arrive on ch2, ch0, ch1 in cycles 2, 5, 9 after `fence_t_i` → `flush_req_o` goes 111, 011, 010, 000; DRAIN entered in cycle 10.
- `busy_i[1]` pulses once 7 cycles into DRAIN (DrainCycles=16) → PAD entered 16 idle cycles after `busy_i` falls.
- pad_src=0, `pad_cycles_i`=100, timer edge 30 cycles before DRAIN exit → `pad_ceil_o`=30 with a one-cycle valid; PAD lasts 70 cycles.
- pad_src=2, `pc_commit_i`=0x8000_0ffc → RST_UARCH the cycle after PAD entry; `uarch_rst_o` high exactly RstCycles cycles; `rst_addr_o`=0x8000_1000; `done_o` pulses once.
- Second `fence_t_i` during PAD plus a spurious ack in IDLE → both ignored; state and `pending_q` unchanged.
- `rst_i` asserted during RST_UARCH → next cycle state IDLE, `halt_o`=0, `rst_addr_o`=`boot_addr_i`, no `done_o`.
